// File: rtl/colour_map_pkg.sv
// Shared types and helpers for the colour-map interpolator: FSM states, mode
// encodings, colour field extraction and depth clamping.
package colour_map_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIVIDE,
        RUN,
        DONE
    } state_t;

    localparam logic LINEAR = 1'b0;
    localparam logic CYCLIC = 1'b1;

    function automatic logic [31:0] field_mask(input int bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

    // Colours are packed {R,G,B} with red in the most significant bits.
    function automatic logic [31:0] get_r(input logic [31:0] c, input int r_bits,
                                          input int g_bits, input int b_bits);
        return (c >> (g_bits + b_bits)) & field_mask(r_bits);
    endfunction

    function automatic logic [31:0] get_g(input logic [31:0] c, input int g_bits,
                                          input int b_bits);
        return (c >> b_bits) & field_mask(g_bits);
    endfunction

    function automatic logic [31:0] get_b(input logic [31:0] c, input int b_bits);
        return c & field_mask(b_bits);
    endfunction

    function automatic logic [31:0] clamp_depth(input logic [31:0] d, input int max_d);
        logic [31:0] mx;
        mx = 32'(max_d);
        if (d == 32'd0) return 32'd1;
        if (d > mx) return mx;
        return d;
    endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring unsigned divider, one quotient bit per cycle. done is high during
// the final step; quotient and remainder are valid from the following cycle.
module serial_divider #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);
    localparam int CNT_W = $clog2(W + 1);

    logic [W-1:0]     quo, rem, dsr, diff;
    logic [W:0]       rem_sh;
    logic [CNT_W-1:0] cnt;
    logic             ge;

    assign rem_sh = {rem, quo[W-1]};
    assign ge     = rem_sh >= {1'b0, dsr};
    assign diff   = rem_sh[W-1:0] - dsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            quo <= '0;
            rem <= '0;
            dsr <= '0;
            cnt <= '0;
        end else if (start) begin
            quo <= dividend;
            rem <= '0;
            dsr <= divisor;
            cnt <= CNT_W'(W);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            if (ge) begin
                rem <= diff;
                quo <= {quo[W-2:0], 1'b1};
            end else begin
                rem <= rem_sh[W-1:0];
                quo <= {quo[W-2:0], 1'b0};
            end
        end
    end

    assign busy      = (cnt != '0);
    assign done      = (cnt == CNT_W'(1));
    assign quotient  = quo;
    assign remainder = rem;

endmodule

// File: rtl/colour_map_interp.sv
// Colour-map generator: linearly interpolates between key colours at evenly
// spaced fixed-point positions and streams the entries out with valid/ready.
//   state  | meaning
//   IDLE   | waiting for req
//   LOAD   | request accepted (ack), divider started
//   DIVIDE | computing position increment
//   RUN    | emitting entries with backpressure
//   DONE   | one-cycle completion pulse
module colour_map_interp #(
    parameter int N_KEYS    = 6,
    parameter int R_BITS    = 5,
    parameter int G_BITS    = 6,
    parameter int B_BITS    = 5,
    parameter int MAX_DEPTH = 1024,
    parameter int FRAC_BITS = 16,
    localparam int CW    = R_BITS + G_BITS + B_BITS,
    localparam int IDX_W = $clog2(MAX_DEPTH),
    localparam int SEG_W = $clog2(N_KEYS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    output logic                 ack,
    output logic                 busy,
    output logic                 done,
    input  logic [N_KEYS*CW-1:0] key_colours,
    input  logic [IDX_W:0]       depth,
    input  logic                 cyclic,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDX_W-1:0]     out_index,
    output logic [CW-1:0]        out_colour
);
    import colour_map_pkg::*;

    localparam int W = SEG_W + FRAC_BITS;
    localparam logic [IDX_W:0] ONE_D = 1;

    state_t                state, state_n;
    logic [N_KEYS*CW-1:0]  keys_lat;
    logic                  cyc_lat;
    logic [IDX_W:0]        d_lat, v_div, i_cnt;
    logic [SEG_W-1:0]      s_cnt, seg_max, pos_int, seg, seg_nxt;
    logic [W-1:0]          pos, inc, div_q, div_rem_unused;
    logic [FRAC_BITS-1:0]  t;
    logic [CW-1:0]         key_arr [N_KEYS];
    logic [CW-1:0]         c0, c1, entry_colour;
    logic                  div_start, div_done, div_busy_unused;
    logic                  load_entry, last_entry, force_last;

    function automatic logic [31:0] lerp(input logic [31:0] a, input logic [31:0] b,
                                         input logic [FRAC_BITS-1:0] frac, input int bits);
        longint diff, res, hi;
        diff = longint'(b) - longint'(a);
        res  = longint'(a) + ((diff * longint'(frac) + (longint'(1) <<< (FRAC_BITS - 1)))
                              >>> FRAC_BITS);
        hi   = (longint'(1) <<< bits) - 1;
        if (res < 0) res = 0;
        else if (res > hi) res = hi;
        return res[31:0];
    endfunction

    always_comb begin
        for (int k = 0; k < N_KEYS; k++) key_arr[k] = keys_lat[k*CW +: CW];
    end

    assign s_cnt   = (cyc_lat == CYCLIC) ? SEG_W'(N_KEYS) : SEG_W'(N_KEYS - 1);
    assign v_div   = (cyc_lat == CYCLIC) ? d_lat : d_lat - ONE_D;
    assign inc     = (v_div == '0) ? '0 : div_q;
    assign pos_int = pos[W-1:FRAC_BITS];
    assign t       = pos[FRAC_BITS-1:0];
    assign seg_max = s_cnt - 1'b1;
    assign seg     = (pos_int > seg_max) ? seg_max : pos_int;
    assign seg_nxt = (seg == SEG_W'(N_KEYS - 1)) ? '0 : seg + 1'b1;
    assign c0      = key_arr[seg];
    assign c1      = key_arr[seg_nxt];

    // A single-entry linear map has no span to correct, so it keeps key0.
    assign last_entry = (i_cnt == d_lat - ONE_D);
    assign force_last = (cyc_lat == LINEAR) && (d_lat != ONE_D) && last_entry;

    always_comb begin
        entry_colour = key_arr[N_KEYS-1];
        if (!force_last) begin
            entry_colour = {
                R_BITS'(lerp(get_r(32'(c0), R_BITS, G_BITS, B_BITS),
                             get_r(32'(c1), R_BITS, G_BITS, B_BITS), t, R_BITS)),
                G_BITS'(lerp(get_g(32'(c0), G_BITS, B_BITS),
                             get_g(32'(c1), G_BITS, B_BITS), t, G_BITS)),
                B_BITS'(lerp(get_b(32'(c0), B_BITS),
                             get_b(32'(c1), B_BITS), t, B_BITS))
            };
        end
    end

    serial_divider #(.W(W)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  ({s_cnt, {FRAC_BITS{1'b0}}}),
        .divisor   (W'(v_div)),
        .busy      (div_busy_unused),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_rem_unused)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        div_start  = 1'b0;
        load_entry = 1'b0;
        case (state)
            IDLE:   if (req) state_n = LOAD;
            LOAD: begin
                div_start = (v_div != '0);
                state_n   = (v_div == '0) ? RUN : DIVIDE;
            end
            DIVIDE: if (div_done) state_n = RUN;
            RUN: begin
                if (out_valid && out_ready && (i_cnt == d_lat))
                    state_n = DONE;
                else if ((!out_valid || out_ready) && (i_cnt != d_lat))
                    load_entry = 1'b1;
            end
            DONE:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            keys_lat   <= '0;
            cyc_lat    <= LINEAR;
            d_lat      <= ONE_D;
            pos        <= '0;
            i_cnt      <= '0;
            out_valid  <= 1'b0;
            out_index  <= '0;
            out_colour <= '0;
        end else begin
            if (state == IDLE && req) begin
                keys_lat <= key_colours;
                cyc_lat  <= cyclic;
                d_lat    <= (IDX_W+1)'(clamp_depth(32'(depth), MAX_DEPTH));
            end
            if (state == LOAD) begin
                pos   <= '0;
                i_cnt <= '0;
            end
            if (load_entry) begin
                out_valid  <= 1'b1;
                out_index  <= i_cnt[IDX_W-1:0];
                out_colour <= entry_colour;
                i_cnt      <= i_cnt + ONE_D;
                if (!last_entry) pos <= pos + inc;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign ack  = (state == LOAD);
    assign busy = (state == LOAD) || (state == DIVIDE) || (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_colour_map_interp.sv
// Directed bench for colour_map_interp: full-sequence model checks plus a table
// of hand-computed entries, backpressure, clamping, busy-req and reset cases.
module tb_colour_map_interp;
    localparam int N_KEYS = 6;
    localparam int CW     = 16;
    localparam int IDX_W  = 10;

    logic                 clk = 1'b0;
    logic                 reset, req, ack, busy, done, cyclic, out_valid, out_ready;
    logic [N_KEYS*CW-1:0] key_colours;
    logic [IDX_W:0]       depth;
    logic [IDX_W-1:0]     out_index;
    logic [CW-1:0]        out_colour;

    int checks = 0;
    int errors = 0;

    logic [15:0] keys [N_KEYS];
    logic [15:0] cap  [5][1024];

    typedef struct {
        int          sc;
        int          idx;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl [17];

    always #5 clk = ~clk;

    colour_map_interp #(
        .N_KEYS(6), .R_BITS(5), .G_BITS(6), .B_BITS(5),
        .MAX_DEPTH(1024), .FRAC_BITS(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .ack        (ack),
        .busy       (busy),
        .done       (done),
        .key_colours(key_colours),
        .depth      (depth),
        .cyclic     (cyclic),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_index  (out_index),
        .out_colour (out_colour)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic int mch(input int a, input int b, input int t, input int mx);
        int r;
        r = a + ((((b - a) * t) + 32768) >>> 16);
        if (r < 0) r = 0;
        if (r > mx) r = mx;
        return r;
    endfunction

    function automatic logic [15:0] model(input int d, input bit cyc, input int i);
        int s, v, inc, pos, seg, t, nx;
        logic [15:0] a, b;
        s   = cyc ? 6 : 5;
        v   = cyc ? d : d - 1;
        inc = (v == 0) ? 0 : (s * 65536) / v;
        if (!cyc && d > 1 && i == d - 1) return keys[5];
        pos = i * inc;
        seg = pos / 65536;
        if (seg > s - 1) seg = s - 1;
        t   = pos % 65536;
        nx  = (seg + 1) % 6;
        a   = keys[seg];
        b   = keys[nx];
        return {5'(mch(int'(a[15:11]), int'(b[15:11]), t, 31)),
                6'(mch(int'(a[10:5]),  int'(b[10:5]),  t, 63)),
                5'(mch(int'(a[4:0]),   int'(b[4:0]),   t, 31))};
    endfunction

    task automatic start_op(input int d, input bit cyc);
        depth  = 11'(d);
        cyclic = cyc;
        for (int k = 0; k < N_KEYS; k++) key_colours[k*CW +: CW] = keys[k];
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("ack_on_accept", 32'(ack), 1);
        chk("busy_on_accept", 32'(busy), 1);
    endtask

    task automatic run_capture(input int sc, input int d_model, input bit cyc,
                               input int n_exp, input int lat_exp,
                               input int stall_at, input int stall_len, input int pulse_at);
        int c, n, first, acks, dones, stall_left;
        c = 1; n = 0; first = -1; acks = 0; dones = 0; stall_left = stall_len;
        @(negedge clk);
        while (dones == 0 && c < 3000) begin
            req       = (c == pulse_at);
            out_ready = 1'b1;
            if (ack) acks++;
            if (done) begin
                dones++;
                chk("busy_low_at_done", 32'(busy), 0);
                chk("valid_low_at_done", 32'(out_valid), 0);
            end
            if (out_valid) begin
                if (first < 0) first = c;
                if (int'(out_index) == stall_at && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                    chk("stall_index_held", 32'(out_index), 32'(stall_at));
                    chk("stall_colour_held", 32'(out_colour), 32'(model(d_model, cyc, stall_at)));
                end
                if (out_ready) begin
                    chk($sformatf("s%0d_index%0d", sc, n), 32'(out_index), 32'(n));
                    chk($sformatf("s%0d_colour%0d", sc, n), 32'(out_colour),
                        32'(model(d_model, cyc, n)));
                    if (n < 1024) cap[sc][n] = out_colour;
                    n++;
                end
            end
            @(negedge clk);
            c++;
        end
        req       = 1'b0;
        out_ready = 1'b1;
        chk($sformatf("s%0d_entry_count", sc), 32'(n), 32'(n_exp));
        chk($sformatf("s%0d_done_pulses", sc), 32'(dones), 1);
        chk($sformatf("s%0d_done_one_cycle", sc), 32'(done), 0);
        chk($sformatf("s%0d_no_ack_while_busy", sc), 32'(acks), 0);
        chk($sformatf("s%0d_first_valid_latency", sc), 32'(first), 32'(lat_exp));
        if (stall_len > 0) chk("stall_fully_applied", 32'(stall_left), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, vcount;
        bit hit;

        keys[0] = 16'h0000; keys[1] = 16'hF800; keys[2] = 16'h07E0;
        keys[3] = 16'h001F; keys[4] = 16'hFFFF; keys[5] = 16'h8410;

        tbl[0]  = '{0, 0,    16'h0000};
        tbl[1]  = '{0, 1,    16'hF800};
        tbl[2]  = '{0, 2,    16'h07E0};
        tbl[3]  = '{0, 3,    16'h001F};
        tbl[4]  = '{0, 4,    16'hFFFF};
        tbl[5]  = '{0, 5,    16'h8410};
        tbl[6]  = '{1, 0,    16'h0000};
        tbl[7]  = '{1, 1,    16'h8000};
        tbl[8]  = '{1, 3,    16'h8400};
        tbl[9]  = '{1, 4,    16'h07E0};
        tbl[10] = '{1, 10,   16'h8410};
        tbl[11] = '{2, 0,    16'h0000};
        tbl[12] = '{2, 10,   16'h8410};
        tbl[13] = '{2, 11,   16'h4208};
        tbl[14] = '{3, 0,    16'h0000};
        tbl[15] = '{4, 0,    16'h0000};
        tbl[16] = '{4, 1023, 16'h8410};

        reset = 1'b1; req = 1'b0; out_ready = 1'b1; cyclic = 1'b0;
        depth = '0; key_colours = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_ack", 32'(ack), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_index", 32'(out_index), 0);
        chk("reset_colour", 32'(out_colour), 0);

        start_op(6, 1'b0);
        run_capture(0, 6, 1'b0, 6, 21, -1, 0, 5);

        start_op(11, 1'b0);
        run_capture(1, 11, 1'b0, 11, 21, 4, 3, -1);

        start_op(12, 1'b1);
        run_capture(2, 12, 1'b1, 12, 21, -1, 0, -1);

        start_op(0, 1'b0);
        run_capture(3, 1, 1'b0, 1, 2, -1, 0, -1);

        start_op(2000, 1'b0);
        run_capture(4, 1024, 1'b0, 1024, 21, -1, 0, 300);

        // Reset while entry 7 is on the output.
        start_op(11, 1'b0);
        c = 0; hit = 1'b0;
        while (!hit && c < 100) begin
            out_ready = 1'b1;
            if (out_valid && out_index == 10'd7) hit = 1'b1;
            else begin
                @(negedge clk);
                c++;
            end
        end
        chk("reached_entry7", 32'(hit), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_busy", 32'(busy), 0);
        chk("midreset_valid", 32'(out_valid), 0);
        chk("midreset_done", 32'(done), 0);
        chk("midreset_ack", 32'(ack), 0);
        chk("midreset_index", 32'(out_index), 0);
        chk("midreset_colour", 32'(out_colour), 0);
        reset = 1'b0;
        vcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid || busy || done) vcount++;
        end
        chk("silent_after_reset", 32'(vcount), 0);

        for (int k = 0; k < 17; k++) begin
            chk($sformatf("tbl_s%0d_entry%0d", tbl[k].sc, tbl[k].idx),
                32'(cap[tbl[k].sc][tbl[k].idx]), 32'(tbl[k].exp));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
